// File: rtl/carbon_seq.sv
`default_nettype none
// carbon_seq: run-control sequencer (fetch handshake, phase A/B strobes, go/step/halt/breakpoint).
// Revision 1.0
module carbon_seq #(
    parameter int GAP     = 1,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        step,
    input  logic        halt_req,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    input  logic [7:0]  pc,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ph_a,
    output logic        ph_b,
    output logic        halted,
    output logic        err,
    output logic [15:0] icount
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_PHA    = 3'd2,
        S_GAPA   = 3'd3,
        S_PHB    = 3'd4,
        S_GAPB   = 3'd5,
        S_RETIRE = 3'd6
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] GAP_LAST  = 3'(GAP - 1);
    localparam bit         NO_GAP    = (GAP == 0);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [2:0] gap_cnt;
    logic       halt_pending;
    logic       step_mode;
    logic       first_flag;

    logic start;
    logic wait_last;
    logic gap_last;
    logic bp_hit;
    logic retire_stop;

    assign start       = go | step;
    assign wait_last   = (wait_cnt == WAIT_LAST);
    assign gap_last    = (gap_cnt == GAP_LAST);
    // first_flag lets an instruction resumed from its own breakpoint run without re-trapping
    assign bp_hit      = bp_en && (pc == bp_addr) && !first_flag;
    assign retire_stop = halt_pending | step_mode | bp_hit;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ack)       state_nxt = S_PHA;
                else if (wait_last) state_nxt = S_IDLE;
            end
            S_PHA:    state_nxt = NO_GAP ? S_PHB : S_GAPA;
            S_GAPA:   if (gap_last) state_nxt = S_PHB;
            S_PHB:    state_nxt = NO_GAP ? S_RETIRE : S_GAPB;
            S_GAPB:   if (gap_last) state_nxt = S_RETIRE;
            S_RETIRE: state_nxt = retire_stop ? S_IDLE : S_FETCH;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe is glitch-free for the core clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            imem_req     <= 1'b0;
            ph_a         <= 1'b0;
            ph_b         <= 1'b0;
            halted       <= 1'b1;
            err          <= 1'b0;
            icount       <= 16'd0;
            wait_cnt     <= 8'd0;
            gap_cnt      <= 3'd0;
            halt_pending <= 1'b0;
            step_mode    <= 1'b0;
            first_flag   <= 1'b0;
        end else begin
            state    <= state_nxt;
            imem_req <= (state_nxt == S_FETCH);
            ph_a     <= (state_nxt == S_PHA);
            ph_b     <= (state_nxt == S_PHB);
            halted   <= (state_nxt == S_IDLE);

            wait_cnt <= (state == S_FETCH) ? wait_cnt + 8'd1 : 8'd0;
            gap_cnt  <= (state == S_GAPA || state == S_GAPB) ? gap_cnt + 3'd1 : 3'd0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        step_mode  <= step;
                        first_flag <= 1'b1;
                        err        <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (!imem_ack && wait_last) err <= 1'b1;
                end
                S_RETIRE: begin
                    icount     <= icount + 16'd1;
                    first_flag <= 1'b0;
                end
                default: ;
            endcase

            if (state != S_IDLE && halt_req) halt_pending <= 1'b1;
            if (state_nxt == S_IDLE)         halt_pending <= 1'b0;
        end
    end

endmodule
`default_nettype wire
